// File: rtl/multi_lfsr_stream_cipher.sv
// Byte-wide stream cipher: three keyed-IV Fibonacci LFSRs, XOR-mixed and
// S-box whitened per nibble, XORed onto the data byte with one cycle latency.
module multi_lfsr_stream_cipher #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key1,
    input  logic [WIDTH-1:0] key2,
    input  logic [WIDTH-1:0] key3,
    input  logic [WIDTH-1:0] iv1,
    input  logic [WIDTH-1:0] iv2,
    input  logic [WIDTH-1:0] iv3,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    localparam int unsigned NIB_W = 4;

    logic [WIDTH-1:0] lfsr1;
    logic [WIDTH-1:0] lfsr2;
    logic [WIDTH-1:0] lfsr3;
    logic [WIDTH-1:0] seed1_c;
    logic [WIDTH-1:0] seed2_c;
    logic [WIDTH-1:0] seed3_c;
    logic [WIDTH-1:0] next1_c;
    logic [WIDTH-1:0] next2_c;
    logic [WIDTH-1:0] next3_c;
    logic [WIDTH-1:0] mix_c;
    logic [WIDTH-1:0] ks_c;

    // 4-bit whitening S-box
    function automatic logic [NIB_W-1:0] sbox(input logic [NIB_W-1:0] n);
        logic [NIB_W-1:0] r;
        case (n)
            4'h0: r = 4'hC;
            4'h1: r = 4'h5;
            4'h2: r = 4'h6;
            4'h3: r = 4'hB;
            4'h4: r = 4'h9;
            4'h5: r = 4'h0;
            4'h6: r = 4'hA;
            4'h7: r = 4'hD;
            4'h8: r = 4'h3;
            4'h9: r = 4'hE;
            4'hA: r = 4'hF;
            4'hB: r = 4'h8;
            4'hC: r = 4'h4;
            4'hD: r = 4'h7;
            4'hE: r = 4'h1;
            default: r = 4'h2;
        endcase
        return r;
    endfunction

    // All-zero seeds would lock an LFSR, so they are forced to 1
    function automatic logic [WIDTH-1:0] guard_seed(input logic [WIDTH-1:0] s);
        return (s == '0) ? WIDTH'(1) : s;
    endfunction

    // Seeds, next LFSR states and keystream byte
    always_comb begin
        seed1_c = guard_seed(key1 ^ iv1);
        seed2_c = guard_seed(key2 ^ iv2);
        seed3_c = guard_seed(key3 ^ iv3);
        next1_c = {lfsr1[6:0], lfsr1[7] ^ lfsr1[5] ^ lfsr1[4] ^ lfsr1[3]};
        next2_c = {lfsr2[6:0], lfsr2[7] ^ lfsr2[3] ^ lfsr2[2] ^ lfsr2[1]};
        next3_c = {lfsr3[6:0], lfsr3[7] ^ lfsr3[4] ^ lfsr3[2] ^ lfsr3[1]};
        mix_c   = lfsr1 ^ lfsr2 ^ lfsr3;
        ks_c    = {sbox(mix_c[7:4]), sbox(mix_c[3:0])};
    end

    // Reload seeds while in reset, otherwise encrypt one byte and step
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr1    <= seed1_c;
            lfsr2    <= seed2_c;
            lfsr3    <= seed3_c;
            data_out <= '0;
        end else begin
            lfsr1    <= next1_c;
            lfsr2    <= next2_c;
            lfsr3    <= next3_c;
            data_out <= data_in ^ ks_c;
        end
    end

endmodule

// File: tb/tb_multi_lfsr_stream_cipher.sv
// Bench for multi_lfsr_stream_cipher: polynomial-mask reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_multi_lfsr_stream_cipher;

    logic       clk;
    logic       rst;
    logic [7:0] key1, key2, key3, iv1, iv2, iv3;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int tests;
    int fails;

    localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;
    localparam logic [7:0]  POLY1 = 8'b1011_1000;
    localparam logic [7:0]  POLY2 = 8'b1000_1110;
    localparam logic [7:0]  POLY3 = 8'b1001_0110;

    multi_lfsr_stream_cipher #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .key1(key1), .key2(key2), .key3(key3),
        .iv1(iv1), .iv2(iv2), .iv3(iv3),
        .data_in(data_in), .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sb(input logic [3:0] n);
        logic [63:0] t;
        t = SBOX_TBL;
        return t[4*n +: 4];
    endfunction

    function automatic logic [7:0] ks_of(input logic [7:0] m);
        return {sb(m[7:4]), sb(m[3:0])};
    endfunction

    // Shift left, feedback is the parity of the tapped bits
    function automatic logic [7:0] lstep(input logic [7:0] s, input logic [7:0] poly);
        return {s[6:0], ^(s & poly)};
    endfunction

    function automatic logic [7:0] mseed(input logic [7:0] k, input logic [7:0] v);
        logic [7:0] s;
        s = k ^ v;
        return (s == 8'h00) ? 8'h01 : s;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model
    logic [7:0] m1, m2, m3, m_exp;
    logic       m_valid;
    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m1      <= mseed(key1, iv1);
            m2      <= mseed(key2, iv2);
            m3      <= mseed(key3, iv3);
            m_exp   <= 8'h00;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            m_exp <= data_in ^ ks_of(m1 ^ m2 ^ m3);
            m1    <= lstep(m1, POLY1);
            m2    <= lstep(m2, POLY2);
            m3    <= lstep(m3, POLY3);
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (m_valid) check("model", data_out, m_exp);
    end

    task automatic edge_with(input logic r, input logic [7:0] d);
        @(negedge clk);
        rst     = r;
        data_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic set_default_keys();
        key1 = 8'hAA; key2 = 8'hCC; key3 = 8'hF0;
        iv1  = 8'h0F; iv2  = 8'h33; iv3  = 8'h55;
    endtask

    logic [7:0] cipher [10];

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        data_in = 8'h00;
        set_default_keys();

        // Raw keystream
        edge_with(1'b0, 8'h00);
        edge_with(1'b0, 8'h00);
        check("reset_out", data_out, 8'h00);
        edge_with(1'b1, 8'h00);
        check("ks0", data_out, 8'h22);
        edge_with(1'b1, 8'h00);
        check("ks1", data_out, 8'h21);
        edge_with(1'b1, 8'h00);

        // Encrypt A5
        edge_with(1'b0, 8'hA5);
        check("reset_out2", data_out, 8'h00);
        edge_with(1'b1, 8'hA5);
        check("enc0", data_out, 8'h87);
        edge_with(1'b1, 8'hA5);
        check("enc1", data_out, 8'h84);

        // Round trip
        edge_with(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            edge_with(1'b1, 8'hA5);
            cipher[i] = data_out;
        end
        edge_with(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            edge_with(1'b1, cipher[i]);
            check("roundtrip", data_out, 8'hA5);
        end

        // Zero-seed guard on LFSR1
        key1 = 8'h3C; iv1 = 8'h3C;
        edge_with(1'b0, 8'h00);
        check("zs_reset", data_out, 8'h00);
        edge_with(1'b1, 8'h00);
        check("zs_ks0", data_out, 8'h08);
        edge_with(1'b1, 8'h00);
        check("zs_ks1", data_out, 8'h8A);
        set_default_keys();

        // Reset mid-stream, held for several cycles
        edge_with(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) edge_with(1'b1, 8'h00);
        edge_with(1'b0, 8'h00);
        check("mid_reset", data_out, 8'h00);
        edge_with(1'b0, 8'h00);
        edge_with(1'b0, 8'h00);
        edge_with(1'b1, 8'h00);
        check("mid_ks0", data_out, 8'h22);
        edge_with(1'b1, 8'h00);
        check("mid_ks1", data_out, 8'h21);

        // Key/IV changes while running are ignored
        edge_with(1'b0, 8'h00);
        edge_with(1'b1, 8'h00);
        check("kc_ks0", data_out, 8'h22);
        key1 = 8'h3C; iv1 = 8'h11; key2 = 8'h00;
        edge_with(1'b1, 8'h00);
        check("kc_ks1", data_out, 8'h21);
        for (int i = 0; i < 20; i++) edge_with(1'b1, 8'(i * 37));
        set_default_keys();

        // Longer run with varied data
        edge_with(1'b0, 8'h00);
        for (int i = 0; i < 300; i++) edge_with(1'b1, 8'($urandom_range(0, 255)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
